// File: rtl/rv_2_pa_iu_xocc_mch_pkg.sv
// Shared decode constants and result codes for the XOCC multi-channel unit.
package rv_2_pa_xocc_pkg;
   localparam int FUNC_NORM = 0;
   localparam int FUNC_DLY  = 1;

   // Normal-class (query) sub-function bits
   localparam int SUB_PUSH_RDY = 0;
   localparam int SUB_POP_RDY  = 1;
   localparam int SUB_READ_RSP = 2;
   localparam int SUB_COUNT    = 3;

   // Delayed-class (side-effect) sub-function bits
   localparam int SUB_PUSH_CMD  = 0;
   localparam int SUB_WRITE_CMD = 1;
   localparam int SUB_POP_RSP   = 2;
   localparam int SUB_CLR_STAGE = 3;

   localparam logic [31:0] RES_FAIL       = 32'd0;
   localparam logic [31:0] RES_OK         = 32'd1;
   localparam logic [31:0] RES_INCOMPLETE = 32'd2;

   localparam int RS2_Q_LSB = 0;
   localparam int RS2_F_LSB = 4;
endpackage

// File: rtl/rv_2_pa_iu_xocc_mch_fifo.sv
// First-word-fall-through synchronous FIFO; pointers carry a wrap bit above the address.
module xocc_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_rdata,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (i_push) r_wptr <= r_wptr + 1'b1;
         if (i_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

   // Storage is not reset: an empty FIFO never exposes stale entries as valid.
   always_ff @(posedge i_clk) begin
      if (i_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
   end

   assign o_rdata = r_mem[r_rptr[AW-1:0]];
   assign o_count = r_wptr - r_rptr;
   assign o_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
   assign o_empty = (r_wptr == r_rptr);
endmodule

// File: rtl/rv_2_pa_iu_xocc_mch.sv
// XOCC custom-instruction unit: per-channel staging buffers feeding command FIFOs,
// response FIFOs back from the DSAs, and same-cycle completion to the RTU.
module rv_2_pa_iu_xocc_mch
   import rv_2_pa_xocc_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int CMD_WORDS   = 3,
   parameter int RSP_WORDS   = 1,
   parameter int FIFO_DEPTH  = 16,
   parameter int QUEUE_WIDTH = 4,
   parameter int FIELD_WIDTH = 8
) (
   input  logic                              forever_cpuclk,
   input  logic                              cpurst_b,
   input  logic                              idu_iu_ex1_inst_vld,
   input  logic                              idu_iu_ex1_xocc_sel,
   input  logic [4:0]                        idu_xocc_ex1_func,
   input  logic [4:0]                        idu_xocc_ex1_sub_func,
   input  logic [31:0]                       idu_xocc_ex1_rs1,
   input  logic [31:0]                       idu_xocc_ex1_rs2,
   output logic                              iu_rtu_ex1_xocc_cmplt,
   output logic [31:0]                       iu_rtu_ex1_xocc_data,
   output logic [NUM_CH*CMD_WORDS*32-1:0]    dsa_cmd_data,
   output logic [NUM_CH-1:0]                 dsa_cmd_vld,
   input  logic [NUM_CH-1:0]                 dsa_cmd_rdy,
   input  logic [NUM_CH*RSP_WORDS*32-1:0]    dsa_rsp_data,
   input  logic [NUM_CH-1:0]                 dsa_rsp_vld,
   output logic [NUM_CH-1:0]                 dsa_rsp_rdy
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = CMD_WORDS * 32;
   localparam int RW = RSP_WORDS * 32;

   logic                 w_norm;
   logic                 w_dly;
   logic [31:0]          w_q;
   logic [31:0]          w_f;
   logic                 w_op_push;
   logic                 w_op_wr;
   logic                 w_op_pop;
   logic                 w_op_clr;
   logic [NUM_CH-1:0]    w_q_hit;
   logic [NUM_CH-1:0]    w_cmd_push;
   logic [NUM_CH-1:0]    w_cmd_pop;
   logic [NUM_CH-1:0]    w_cmd_full;
   logic [NUM_CH-1:0]    w_cmd_empty;
   logic [NUM_CH-1:0]    w_rsp_push;
   logic [NUM_CH-1:0]    w_rsp_pop;
   logic [NUM_CH-1:0]    w_rsp_full;
   logic [NUM_CH-1:0]    w_rsp_empty;
   logic [AW:0]          w_cmd_cnt  [NUM_CH];
   logic [AW:0]          w_rsp_cnt  [NUM_CH];
   logic [RW-1:0]        w_rsp_head [NUM_CH];
   logic [CW-1:0]        r_stage    [NUM_CH];
   logic [CMD_WORDS-1:0] r_mask     [NUM_CH];
   logic [31:0]          w_res;
   logic                 w_unused_ok;

   assign w_norm = idu_xocc_ex1_func[FUNC_NORM] & idu_iu_ex1_xocc_sel;
   assign w_dly  = idu_xocc_ex1_func[FUNC_DLY] & idu_iu_ex1_xocc_sel & idu_iu_ex1_inst_vld;
   assign w_q    = 32'(idu_xocc_ex1_rs2[RS2_Q_LSB +: QUEUE_WIDTH]);
   assign w_f    = 32'(idu_xocc_ex1_rs2[RS2_F_LSB +: FIELD_WIDTH]);

   // Delayed ops are priority-encoded so only one side effect fires per instruction.
   assign w_op_push = w_dly & idu_xocc_ex1_sub_func[SUB_PUSH_CMD];
   assign w_op_wr   = w_dly & ~idu_xocc_ex1_sub_func[SUB_PUSH_CMD] & idu_xocc_ex1_sub_func[SUB_WRITE_CMD];
   assign w_op_pop  = w_dly & (idu_xocc_ex1_sub_func[1:0] == 2'b00) & idu_xocc_ex1_sub_func[SUB_POP_RSP];
   assign w_op_clr  = w_dly & (idu_xocc_ex1_sub_func[2:0] == 3'b000) & idu_xocc_ex1_sub_func[SUB_CLR_STAGE];

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign w_q_hit[c]     = (w_q == 32'(c));
      assign w_cmd_push[c]  = w_op_push & w_q_hit[c] & ~w_cmd_full[c] & (&r_mask[c]);
      assign w_cmd_pop[c]   = ~w_cmd_empty[c] & dsa_cmd_rdy[c];
      assign w_rsp_push[c]  = dsa_rsp_vld[c] & ~w_rsp_full[c];
      assign w_rsp_pop[c]   = w_op_pop & w_q_hit[c] & ~w_rsp_empty[c];
      assign dsa_cmd_vld[c] = ~w_cmd_empty[c];
      assign dsa_rsp_rdy[c] = ~w_rsp_full[c];

      xocc_sync_fifo #(.WIDTH(CW), .DEPTH(FIFO_DEPTH)) u_cmd_fifo (
         .i_clk   (forever_cpuclk),
         .i_rst_n (cpurst_b),
         .i_push  (w_cmd_push[c]),
         .i_wdata (r_stage[c]),
         .i_pop   (w_cmd_pop[c]),
         .o_rdata (dsa_cmd_data[c*CW +: CW]),
         .o_count (w_cmd_cnt[c]),
         .o_full  (w_cmd_full[c]),
         .o_empty (w_cmd_empty[c])
      );

      xocc_sync_fifo #(.WIDTH(RW), .DEPTH(FIFO_DEPTH)) u_rsp_fifo (
         .i_clk   (forever_cpuclk),
         .i_rst_n (cpurst_b),
         .i_push  (w_rsp_push[c]),
         .i_wdata (dsa_rsp_data[c*RW +: RW]),
         .i_pop   (w_rsp_pop[c]),
         .o_rdata (w_rsp_head[c]),
         .o_count (w_rsp_cnt[c]),
         .o_full  (w_rsp_full[c]),
         .o_empty (w_rsp_empty[c])
      );
   end

   // Staging data survives a push; only the mask clears so every field must be rewritten.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         for (int c = 0; c < NUM_CH; c++) begin
            r_stage[c] <= '0;
            r_mask[c]  <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (w_op_wr && w_q_hit[c]) begin
               for (int w = 0; w < CMD_WORDS; w++) begin
                  if (w_f == 32'(w)) begin
                     r_stage[c][w*32 +: 32] <= idu_xocc_ex1_rs1;
                     r_mask[c][w]           <= 1'b1;
                  end
               end
            end
            if (w_cmd_push[c] || (w_op_clr && w_q_hit[c])) r_mask[c] <= '0;
         end
      end
   end

   always_comb begin
      w_res = RES_FAIL;
      for (int c = 0; c < NUM_CH; c++) begin
         if (w_q_hit[c]) begin
            if (w_norm) begin
               if (idu_xocc_ex1_sub_func[SUB_PUSH_RDY]) w_res = w_res | {31'b0, ~w_cmd_full[c]};
               if (idu_xocc_ex1_sub_func[SUB_POP_RDY])  w_res = w_res | {31'b0, ~w_rsp_empty[c]};
               if (idu_xocc_ex1_sub_func[SUB_READ_RSP] && !w_rsp_empty[c]) begin
                  for (int w = 0; w < RSP_WORDS; w++) begin
                     if (w_f == 32'(w)) w_res = w_res | w_rsp_head[c][w*32 +: 32];
                  end
               end
               if (idu_xocc_ex1_sub_func[SUB_COUNT])
                  w_res = w_res | {16'(w_cmd_cnt[c]), 16'(w_rsp_cnt[c])};
            end
            if (w_op_push && !w_cmd_full[c])
               w_res = w_res | ((&r_mask[c]) ? RES_OK : RES_INCOMPLETE);
            if (w_op_wr && (w_f < 32'(CMD_WORDS))) w_res = w_res | RES_OK;
            if (w_op_pop && !w_rsp_empty[c])       w_res = w_res | RES_OK;
            if (w_op_clr)                          w_res = w_res | RES_OK;
         end
      end
   end

   assign iu_rtu_ex1_xocc_cmplt = idu_iu_ex1_inst_vld & idu_iu_ex1_xocc_sel & (|idu_xocc_ex1_func);
   assign iu_rtu_ex1_xocc_data  = w_res;

   assign w_unused_ok = &{1'b0, idu_xocc_ex1_rs2, idu_xocc_ex1_func, idu_xocc_ex1_sub_func};
endmodule

// File: tb/tb_rv_2_pa_iu_xocc_mch.sv
// Bench for rv_2_pa_iu_xocc_mch: queue-based reference model plus directed scenarios.
module tb_rv_2_pa_iu_xocc_mch;
   localparam int NC = 4;
   localparam int CWD = 3;
   localparam int DEP = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          inst_vld = 1'b0;
   logic          sel = 1'b0;
   logic [4:0]    func = '0;
   logic [4:0]    sub = '0;
   logic [31:0]   rs1 = '0;
   logic [31:0]   rs2 = '0;
   logic          cmplt;
   logic [31:0]   data;
   logic [NC*CWD*32-1:0] cmd_data;
   logic [NC-1:0] cmd_vld;
   logic [NC-1:0] cmd_rdy = '0;
   logic [NC*32-1:0] rsp_data = '0;
   logic [NC-1:0] rsp_vld = '0;
   logic [NC-1:0] rsp_rdy;

   int n_tests = 0;
   int n_fail  = 0;

   logic [CWD*32-1:0] mcmd [NC][$];
   logic [31:0]       mrsp [NC][$];
   logic [31:0]       mstage [NC][CWD];
   logic [CWD-1:0]    mmask [NC];

   localparam logic [4:0] F_NORM = 5'b00001;
   localparam logic [4:0] F_DLY  = 5'b00010;

   rv_2_pa_iu_xocc_mch #(
      .NUM_CH(NC), .CMD_WORDS(CWD), .RSP_WORDS(1), .FIFO_DEPTH(DEP),
      .QUEUE_WIDTH(4), .FIELD_WIDTH(8)
   ) dut (
      .forever_cpuclk        (clk),
      .cpurst_b              (rst_n),
      .idu_iu_ex1_inst_vld   (inst_vld),
      .idu_iu_ex1_xocc_sel   (sel),
      .idu_xocc_ex1_func     (func),
      .idu_xocc_ex1_sub_func (sub),
      .idu_xocc_ex1_rs1      (rs1),
      .idu_xocc_ex1_rs2      (rs2),
      .iu_rtu_ex1_xocc_cmplt (cmplt),
      .iu_rtu_ex1_xocc_data  (data),
      .dsa_cmd_data          (cmd_data),
      .dsa_cmd_vld           (cmd_vld),
      .dsa_cmd_rdy           (cmd_rdy),
      .dsa_rsp_data          (rsp_data),
      .dsa_rsp_vld           (rsp_vld),
      .dsa_rsp_rdy           (rsp_rdy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_res();
      logic [31:0] r;
      int q;
      int f;
      r = 32'd0;
      q = int'(rs2[3:0]);
      f = int'(rs2[11:4]);
      if (!sel || q >= NC) return 32'd0;
      if (func[0]) begin
         if (sub[0]) r |= 32'(mcmd[q].size() < DEP);
         if (sub[1]) r |= 32'(mrsp[q].size() != 0);
         if (sub[2] && f == 0 && mrsp[q].size() != 0) r |= mrsp[q][0];
         if (sub[3]) r |= (32'(mcmd[q].size()) << 16) | 32'(mrsp[q].size());
      end
      if (func[1] && inst_vld) begin
         if (sub[0])      r |= (mcmd[q].size() == DEP) ? 32'd0 : ((mmask[q] == 3'b111) ? 32'd1 : 32'd2);
         else if (sub[1]) r |= 32'(f < CWD);
         else if (sub[2]) r |= 32'(mrsp[q].size() != 0);
         else if (sub[3]) r |= 32'd1;
      end
      return r;
   endfunction

   // Reference model: checked and advanced once per cycle, on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            for (int c = 0; c < NC; c++) begin
               mcmd[c].delete();
               mrsp[c].delete();
               mmask[c] = '0;
               for (int w = 0; w < CWD; w++) mstage[c][w] = '0;
            end
         end
         begin
            logic [NC-1:0] ev;
            logic [NC-1:0] er;
            for (int c = 0; c < NC; c++) begin
               ev[c] = (mcmd[c].size() != 0);
               er[c] = (mrsp[c].size() != DEP);
               if (mcmd[c].size() != 0)
                  check("cmd_head", 128'(cmd_data[c*CWD*32 +: CWD*32]), 128'(mcmd[c][0]));
            end
            check("cmplt", 128'(cmplt), 128'(inst_vld & sel & (|func)));
            check("result", 128'(data), 128'(model_res()));
            check("cmd_vld", 128'(cmd_vld), 128'(ev));
            check("rsp_rdy", 128'(rsp_rdy), 128'(er));
         end
         if (rst_n) begin
            int q;
            int f;
            int ncmd [NC];
            int nrsp [NC];
            logic dly;
            q = int'(rs2[3:0]);
            f = int'(rs2[11:4]);
            dly = sel & inst_vld & func[1] & (q < NC);
            for (int c = 0; c < NC; c++) begin
               ncmd[c] = mcmd[c].size();
               nrsp[c] = mrsp[c].size();
            end
            for (int c = 0; c < NC; c++)
               if (ncmd[c] > 0 && cmd_rdy[c]) void'(mcmd[c].pop_front());
            if (dly && sub[1:0] == 2'b00 && sub[2] && nrsp[q] > 0) void'(mrsp[q].pop_front());
            for (int c = 0; c < NC; c++)
               if (rsp_vld[c] && nrsp[c] < DEP) mrsp[c].push_back(rsp_data[c*32 +: 32]);
            if (dly) begin
               if (sub[0]) begin
                  if (ncmd[q] < DEP && mmask[q] == 3'b111) begin
                     mcmd[q].push_back({mstage[q][2], mstage[q][1], mstage[q][0]});
                     mmask[q] = '0;
                  end
               end else if (sub[1]) begin
                  if (f < CWD) begin
                     mstage[q][f] = rs1;
                     mmask[q][f]  = 1'b1;
                  end
               end else if (!sub[2] && sub[3]) begin
                  mmask[q] = '0;
               end
            end
         end
      end
   end

   function automatic logic [31:0] mk(input int q, input int f);
      return {20'b0, 8'(f), 4'(q)};
   endfunction

   task automatic op(input logic [4:0] fn, input int sb, input logic [31:0] d, input int q, input int f,
                     output logic [31:0] res);
      @(posedge clk);
      #1;
      inst_vld = 1'b1;
      sel      = 1'b1;
      func     = fn;
      sub      = 5'(1 << sb);
      rs1      = d;
      rs2      = mk(q, f);
      #1;
      res = data;
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      inst_vld = 1'b0;
      sel      = 1'b0;
      func     = '0;
      sub      = '0;
      #1;
   endtask

   task automatic fill(input int q, input int tag, output logic [31:0] res);
      logic [31:0] r;
      for (int w = 0; w < CWD; w++) op(F_DLY, 1, 32'(tag * 16 + w), q, w, r);
      op(F_DLY, 0, 32'd0, q, 0, res);
   endtask

   initial begin
      logic [31:0] r;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cmd_vld", 128'(cmd_vld), 128'h0);
      check("rst_rsp_rdy", 128'(rsp_rdy), 128'hF);
      rst_n = 1'b1;
      op(F_NORM, 3, 32'd0, 0, 0, r);  check("rst_count_q0", 128'(r), 128'h0);
      op(F_NORM, 0, 32'd0, 2, 0, r);  check("rst_push_rdy_q2", 128'(r), 128'h1);

      // Incomplete command guard on q1
      op(F_DLY, 1, 32'hC0DE0000, 1, 0, r);
      op(F_DLY, 1, 32'hC0DE0001, 1, 1, r);
      op(F_DLY, 0, 32'd0, 1, 0, r);   check("push_incomplete", 128'(r), 128'h2);
      idle();
      check("q1_vld_stays_0", 128'(cmd_vld[1]), 128'h0);
      op(F_DLY, 1, 32'hC0DE0002, 1, 2, r);
      op(F_DLY, 0, 32'd0, 1, 0, r);   check("push_complete", 128'(r), 128'h1);
      idle();
      check("q1_vld_next", 128'(cmd_vld[1]), 128'h1);
      check("q1_word2", 128'(cmd_data[1*96 + 64 +: 32]), 128'hC0DE0002);
      cmd_rdy[1] = 1'b1;

      // Fill q0 to capacity with the DSA stalled
      for (int i = 0; i < DEP; i++) begin
         fill(0, i, r);
         check("fill_push", 128'(r), 128'h1);
      end
      op(F_NORM, 3, 32'd0, 0, 0, r);  check("full_count", 128'(r), 128'h00100000);
      op(F_NORM, 0, 32'd0, 0, 0, r);  check("full_push_rdy", 128'(r), 128'h0);
      fill(0, 16, r);                 check("push_17", 128'(r), 128'h0);
      op(F_DLY, 0, 32'd0, 0, 0, r);
      cmd_rdy[0] = 1'b1;
      check("push_full_drain", 128'(r), 128'h0);
      op(F_NORM, 3, 32'd0, 0, 0, r);
      cmd_rdy[0] = 1'b0;
      check("count_after_drain", 128'(r), 128'h000F0000);

      // Response path on ch3
      idle();
      @(posedge clk);
      #1;
      rsp_vld[3] = 1'b1;
      rsp_data[3*32 +: 32] = 32'hA5A50001;
      @(posedge clk);
      #1;
      rsp_vld[3] = 1'b0;
      op(F_NORM, 1, 32'd0, 3, 0, r);  check("pop_rdy_ch3", 128'(r), 128'h1);
      op(F_NORM, 2, 32'd0, 3, 0, r);  check("read_rsp_ch3", 128'(r), 128'hA5A50001);
      op(F_DLY, 2, 32'd0, 3, 0, r);   check("pop_rsp_1", 128'(r), 128'h1);
      op(F_DLY, 2, 32'd0, 3, 0, r);   check("pop_rsp_2", 128'(r), 128'h0);

      // Invalid targets
      op(F_DLY, 1, 32'hDEAD0000, 5, 0, r); check("inv_q_write", 128'(r), 128'h0);
      op(F_DLY, 0, 32'd0, 5, 0, r);        check("inv_q_push", 128'(r), 128'h0);
      op(F_NORM, 2, 32'd0, 5, 0, r);       check("inv_q_read", 128'(r), 128'h0);
      op(F_DLY, 1, 32'hDEAD0003, 2, 3, r); check("inv_field_write", 128'(r), 128'h0);
      op(F_DLY, 0, 32'd0, 2, 0, r);        check("inv_field_mask", 128'(r), 128'h2);

      // Reset in the middle of traffic on q2
      for (int i = 0; i < 4; i++) fill(2, 32 + i, r);
      op(F_DLY, 1, 32'h12345678, 2, 0, r);
      op(F_NORM, 3, 32'd0, 2, 0, r);       check("q2_count_pre", 128'(r), 128'h00040000);
      idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int c = 0; c < NC; c++) begin
         op(F_NORM, 3, 32'd0, c, 0, r);
         check("post_rst_count", 128'(r), 128'h0);
      end
      check("post_rst_cmd_vld", 128'(cmd_vld), 128'h0);
      op(F_DLY, 0, 32'd0, 2, 0, r);        check("post_rst_push", 128'(r), 128'h2);
      idle();
      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
